// File: rtl/seq_detect_prg.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Produces a registered match pulse and a saturating match counter.
module seq_detect_prg #(
  parameter int unsigned          MAX_LEN = 8,
  parameter int unsigned          LEN_W   = 5,
  parameter int unsigned          CNT_W   = 10,
  parameter logic [MAX_LEN-1:0]   DEF_PAT = 'b10,
  parameter int unsigned          DEF_LEN = 3,
  parameter bit                   DEF_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic               ovl,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               load_ok;
  logic               match;

  always_comb begin
    hist_n  = {hist_q[MAX_LEN-2:0], x};
    fill_n  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    // Only the low len_q bits of history take part in the compare.
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
    load_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));
    match   = en && !load && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;
    y_d       = match;
    count_d   = count_q;

    if (load) begin
      if (load_ok) begin
        pat_d  = pat;
        len_d  = len;
        ovl_d  = ovl;
        hist_d = '0;
        fill_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_n;
      // Non-overlap mode restarts the fill so matched bits cannot be reused.
      fill_d = (match && !ovl_q) ? '0 : fill_n;
    end

    if (clr_cnt)                       count_d = '0;
    else if (match && count_q != '1)   count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= DEF_PAT;
      len_q     <= LEN_W'(DEF_LEN);
      ovl_q     <= DEF_OVL;
      hist_q    <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      y_q       <= y_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign y       = y_q;
  assign count   = count_q;
  assign cnt_sat = (count_q == '1);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prg.sv
// Directed bench for seq_detect_prg: per-cycle expectations queued at drive time,
// popped and checked after each clock; a CNT_W=2 copy covers counter saturation.
module tb_seq_detect_prg;

  logic       clk, rst, en, x, load, ovl, clr_cnt;
  logic [7:0] pat;
  logic [4:0] len;
  logic       y, cnt_sat, cfg_err;
  logic [9:0] count;
  logic       y_s, cnt_sat_s, cfg_err_s;
  logic [1:0] count_s;

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  typedef struct { logic y; logic err; } exp_t;
  exp_t sb[$];

  seq_detect_prg u_dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat(pat), .len(len),
    .ovl(ovl), .clr_cnt(clr_cnt), .y(y), .count(count), .cnt_sat(cnt_sat),
    .cfg_err(cfg_err)
  );

  seq_detect_prg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat(pat), .len(len),
    .ovl(ovl), .clr_cnt(clr_cnt), .y(y_s), .count(count_s), .cnt_sat(cnt_sat_s),
    .cfg_err(cfg_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: got %0h exp %0h", phase, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue expected y/cfg_err, check after the edge.
  task automatic step(input logic l, input logic e, input logic xx, input logic c,
                      input logic ey, input logic ee);
    exp_t t;
    load = l; en = e; x = xx; clr_cnt = c;
    sb.push_back('{ey, ee});
    @(posedge clk);
    #1;
    t = sb.pop_front();
    chk("y", y, t.y);
    chk("y_s", y_s, t.y);
    chk("cfg_err", cfg_err, t.err);
    load = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 0; x = 0; load = 0; ovl = 0; clr_cnt = 0; pat = '0; len = '0;
    #12;
    chk("y", y, 0); chk("count", count, 0); chk("cnt_sat", cnt_sat, 0);
    chk("cfg_err", cfg_err, 0); chk("count_s", count_s, 0);
    @(posedge clk); #1 rst = 1'b0;

    phase = "default_ovl";
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    chk("count", count, 2);
    step(0,0,1,1, 0,0);
    chk("count_clr", count, 0);

    phase = "no_ovl";
    pat = 8'h02; len = 3; ovl = 0;
    step(1,1,0,0, 0,0);
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    step(0,1,1,0, 0,0); step(0,1,0,0, 0,0);
    chk("count", count, 1);

    phase = "bad_load";
    pat = 8'h02; len = 3; ovl = 1;
    step(1,1,1,1, 0,0);
    chk("count", count, 0);
    step(0,1,0,0, 0,0);
    pat = 8'hFF; len = 0; ovl = 0;
    step(1,1,1,0, 0,1);
    step(0,1,1,0, 0,0);
    len = 9;
    step(1,1,1,0, 0,1);
    step(0,1,0,0, 1,0);
    step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    chk("count", count, 2);

    phase = "len8_gap";
    pat = 8'hB6; len = 8; ovl = 1;
    step(1,1,0,1, 0,0);
    step(0,1,0,0, 0,0); step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 0,0);
    step(0,1,1,0, 0,0); step(0,1,1,0, 0,0);
    step(0,0,1,0, 0,0); step(0,0,0,0, 0,0);
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    step(0,1,1,0, 0,0); step(0,1,1,0, 0,0);
    chk("count", count, 1);

    phase = "len1";
    pat = 8'h01; len = 1; ovl = 1;
    step(1,1,0,1, 0,0);
    step(0,1,1,0, 1,0); step(0,1,0,0, 0,0); step(0,1,1,0, 1,0); step(0,1,1,0, 1,0);
    step(0,0,1,0, 0,0);
    chk("count", count, 3);

    phase = "saturate";
    pat = 8'h02; len = 3; ovl = 1;
    step(1,1,0,1, 0,0);
    for (int r = 0; r < 5; r++) begin
      step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    end
    chk("count", count, 5); chk("cnt_sat", cnt_sat, 0);
    chk("count_s", count_s, 3); chk("cnt_sat_s", cnt_sat_s, 1);
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,1, 1,0);
    chk("count_clr_win", count, 0); chk("count_s_clr_win", count_s, 0);
    chk("cnt_sat_s_clr", cnt_sat_s, 0);

    phase = "mid_reset";
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0);
    rst = 1'b1;
    #1;
    chk("y_in_rst", y, 0); chk("count_in_rst", count, 0);
    @(posedge clk); #1 rst = 1'b0;
    step(0,1,0,0, 0,0); step(0,1,1,0, 0,0); step(0,1,0,0, 1,0);
    chk("count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
